// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared constants for the unified-memory port arbiter of the multi-cycle
//   MIPS32 core: FSM state encodings, owner encodings, the data word returned
//   on a memory timeout, and the arbitration decision helper.
//   Imported by mem_port_arbiter and mem_port_arbiter_if.
package mem_port_arbiter_pkg;

    // FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ARB_S_IDLE = 2'd0;
    localparam logic [1:0] ARB_S_BUSY = 2'd1;
    localparam logic [1:0] ARB_S_DONE = 2'd2;

    // Owner of the access currently in flight
    localparam logic ARB_OWNER_CPU = 1'b0;
    localparam logic ARB_OWNER_LD  = 1'b1;

    // Read data handed back when the memory never answers
    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // CPU has priority; the loader wins when it is alone, or when the CPU
    // has used up its allowed streak of contested grants.
    function automatic logic pick_loader(input logic cpu_req,
                                         input logic ld_req,
                                         input logic streak_full);
        return ld_req & (~cpu_req | streak_full);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three memory handshakes seen by the arbiter:
//     cpu_*  : CPU control FSM request / completion (+ cpu_stall back to FSM)
//     ld_*   : program loader / debug port request / completion
//     mem_*  : unified instruction/data memory model
//   Modports:
//     slave  : the arbiter's view (takes requester requests, drives memory)
//     master : the surrounding system's view (requesters + memory model)
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // CPU side
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;
    // Loader side
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;
    // Memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory between the CPU control FSM and the
//   program loader. CPU has priority; after MAX_CPU_STREAK consecutive
//   contested CPU grants the loader is served once.
//   Each access walks IDLE -> BUSY (mem_req held until mem_ack) -> DONE
//   (one-cycle ack to the owner), so back-to-back grants come every 3 cycles.
//
//   Ports:
//     clk          system clock, rising edge
//     nrst         asynchronous active-low reset
//     bus          mem_port_arbiter_if.slave (cpu_*, ld_*, mem_* handshakes)
//     busy         high whenever the FSM is not IDLE
//     err_timeout  sticky memory-timeout flag
//
//   Optional build macro ARB_TIMEOUT_EN: BUSY gives up after TIMEOUT_CYCLES
//   without mem_ack, completes the access with ARB_TIMEOUT_DATA and sets
//   err_timeout. Without it BUSY waits indefinitely and err_timeout is 0.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_CPU_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                nrst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err_timeout
);

    localparam logic [2:0] STREAK_MAX = 3'(MAX_CPU_STREAK);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ld_rdata_q, ld_rdata_d;
    logic [2:0]    streak_q, streak_d;
    logic          win_ld;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            to_expire;

    // Counter value equals the number of BUSY cycles already completed, so
    // expiry lands on BUSY cycle TIMEOUT_CYCLES+1.
    assign to_expire = (state_q == ARB_S_BUSY) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = '0;
        err_d    = err_q;
        if (state_q == ARB_S_BUSY)
            to_cnt_d = to_cnt_q + 1'b1;
        // A same-cycle mem_ack is a normal completion, not a timeout
        if (to_expire && !bus.mem_ack)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign win_ld = pick_loader(bus.cpu_req, bus.ld_req, streak_q == STREAK_MAX);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        streak_d    = streak_q;

        case (state_q)
            ARB_S_IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    state_d = ARB_S_BUSY;
                    owner_d = win_ld ? ARB_OWNER_LD : ARB_OWNER_CPU;
                    if (win_ld) begin
                        we_d     = bus.ld_we;
                        addr_d   = bus.ld_addr;
                        wdata_d  = bus.ld_wdata;
                        streak_d = '0;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        // Only contested CPU grants count toward the streak
                        if (!bus.ld_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + 3'd1;
                    end
                end
            end

            ARB_S_BUSY: begin
                if (bus.mem_ack) begin
                    state_d = ARB_S_DONE;
                    if (!we_q) begin
                        if (owner_q == ARB_OWNER_LD)
                            ld_rdata_d = bus.mem_rdata;
                        else
                            cpu_rdata_d = bus.mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_expire) begin
                    // Abandoned access: always report the marker word
                    state_d = ARB_S_DONE;
                    if (owner_q == ARB_OWNER_LD)
                        ld_rdata_d = DW'(ARB_TIMEOUT_DATA);
                    else
                        cpu_rdata_d = DW'(ARB_TIMEOUT_DATA);
                end
`endif
            end

            ARB_S_DONE: state_d = ARB_S_IDLE;

            default: state_d = ARB_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ARB_S_IDLE;
            owner_q     <= ARB_OWNER_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            streak_q    <= streak_d;
        end
    end

    // Outputs decode straight from state so reset removes mem_req at once
    assign bus.mem_req   = (state_q == ARB_S_BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_ack   = (state_q == ARB_S_DONE) && (owner_q == ARB_OWNER_CPU);
    assign bus.ld_ack    = (state_q == ARB_S_DONE) && (owner_q == ARB_OWNER_LD);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ld_rdata  = ld_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

    assign busy = (state_q != ARB_S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a table of single-requester
//   accesses, hand-written contention / reset / timeout sequences, and a
//   randomized two-requester run checked against a transaction-level model
//   (grant rule + word memory). Honours ARB_TIMEOUT_EN like the design.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TOC  = 16;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic busy, err_timeout;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_CPU_STREAK(MAXS), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(bus), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model (responder) ----------------
    logic [31:0] tb_mem [0:255];
    int  mem_lat  = 0;
    bit  mem_rand = 1'b0;
    int  wait_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_req === 1'b1 && nrst) begin
            if (wait_cnt >= mem_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
                if (bus.mem_we) tb_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            wait_cnt      = 0;
            if (mem_rand) mem_lat = $urandom_range(0, 3);
        end
    end

    // ---------------- table-driven single accesses ----------------
    typedef struct {
        bit          is_ld;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;  // owner's rdata in the ack cycle
    } vec_t;

    logic [31:0] exp_cpu_rd = '0;
    logic [31:0] exp_ld_rd  = '0;

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bit got;
        @(negedge clk);
        mem_lat = v.lat;
        if (v.is_ld) begin
            bus.ld_req = 1'b1; bus.ld_we = v.we; bus.ld_addr = v.addr; bus.ld_wdata = v.wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
        end
        #1 check({tag, " stall c0"}, bus.cpu_stall, !v.is_ld);
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack || bus.ld_ack) got = 1'b1;
            else begin
                check({tag, " mem_req"}, bus.mem_req, 1'b1);
                check({tag, " payload"}, {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                      {v.we, v.addr, v.wdata});
                if (!v.is_ld) check({tag, " stall busy"}, bus.cpu_stall, 1'b1);
            end
        end
        check({tag, " ack cycle"}, n, v.lat + 2);
        check({tag, " acks"}, {bus.cpu_ack, bus.ld_ack}, v.is_ld ? 2'b01 : 2'b10);
        check({tag, " mem_req in ack"}, bus.mem_req, 1'b0);
        if (v.is_ld) exp_ld_rd = v.exp_rdata; else exp_cpu_rd = v.exp_rdata;
        check({tag, " cpu_rdata"}, bus.cpu_rdata, exp_cpu_rd);
        check({tag, " ld_rdata"}, bus.ld_rdata, exp_ld_rd);
        check({tag, " stall ack"}, bus.cpu_stall, 1'b0);
        drop_reqs();
        @(negedge clk);
        check({tag, " back idle"}, {busy, bus.mem_req, bus.cpu_ack, bus.ld_ack}, 4'b0);
    endtask

    task automatic do_reset();
        drop_reqs();
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        exp_cpu_rd = '0;
        exp_ld_rd  = '0;
    endtask

    // ---------------- random-phase model ----------------
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;

    initial begin
        vec_t vecs [8];
        string tag;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 0; bus.ld_we  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h100 + i;
        tb_mem[8'h04] = 32'h0000_1234;
        tb_mem[8'h20] = 32'h0BAD_F00D;

        vecs[0] = '{0, 0, 32'h10, 32'h0,    0, 32'h0000_1234};
        vecs[1] = '{1, 1, 32'h40, 32'hA5A5, 0, 32'h0};
        vecs[2] = '{0, 0, 32'h40, 32'h0,    5, 32'h0000_A5A5};
        vecs[3] = '{1, 0, 32'h10, 32'h0,    2, 32'h0000_1234};
        vecs[4] = '{0, 1, 32'h10, 32'hCAFE, 1, 32'h0000_A5A5};
        vecs[5] = '{1, 0, 32'h10, 32'h0,    0, 32'h0000_CAFE};
        vecs[6] = '{0, 0, 32'h80, 32'h0,    3, 32'h0BAD_F00D};
        vecs[7] = '{1, 1, 32'h84, 32'h1,    4, 32'h0000_CAFE};

        // reset state
        @(negedge clk);
        check("reset ctrl", {busy, bus.mem_req, bus.cpu_ack, bus.ld_ack, err_timeout, bus.cpu_stall}, 6'b0);
        check("reset rdata", {bus.cpu_rdata, bus.ld_rdata}, 64'h0);
        check("reset payload", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 65'h0);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i], tag);
        end

        // contention: both held, expect C x4, L, C x4, L
        begin
            bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            int k;
            int cyc;
            mem_lat = 0;
            @(negedge clk);
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10; bus.cpu_wdata = 0;
            bus.ld_req  = 1; bus.ld_we  = 0; bus.ld_addr  = 32'h40; bus.ld_wdata  = 0;
            k = 0;
            cyc = 0;
            while (k < 10 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.cpu_ack || bus.ld_ack) begin
                    check($sformatf("contend grant%0d", k), {bus.cpu_ack, bus.ld_ack},
                          exp_seq[k] ? 2'b01 : 2'b10);
                    k++;
                end
            end
            check("contend grants seen", k, 10);
            drop_reqs();
            @(negedge clk);
        end

        // reset in the middle of a long access
        begin
            bit saw_ack;
            mem_lat = 100;
            @(negedge clk);
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
            repeat (2) @(negedge clk);
            check("pre-reset busy", {busy, bus.mem_req}, 2'b11);
            nrst = 1'b0;
            #1;
            check("reset drops mem_req/busy", {busy, bus.mem_req}, 2'b00);
            check("reset clears rdata", bus.cpu_rdata, 32'h0);
            saw_ack = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.cpu_ack || bus.ld_ack) saw_ack = 1'b1;
            end
            drop_reqs();
            nrst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (bus.cpu_ack || bus.ld_ack) saw_ack = 1'b1;
            end
            check("no ack for abandoned access", saw_ack, 1'b0);
            exp_cpu_rd = '0;
            exp_ld_rd  = '0;
            run_vec('{0, 0, 32'h10, 32'h0, 0, 32'h0000_CAFE}, "post-reset");
        end

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            mem_lat = 100000;
            @(negedge clk);
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h80;
            n = 0;
            while (!bus.cpu_ack && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("timeout ack cycle", n, TOC + 2);
            check("timeout rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
            check("timeout flag", err_timeout, 1'b1);
            drop_reqs();
            repeat (3) @(negedge clk);
            check("timeout flag sticky", err_timeout, 1'b1);
        end
`else
        run_vec('{0, 0, 32'h80, 32'h0, 20, 32'h0BAD_F00D}, "long wait");
        check("no timeout flag", err_timeout, 1'b0);
`endif

        // randomized two-requester run
        begin
            txn_t        ct, lt;
            bit          cpu_pend, ld_pend, prev_cpu, prev_ld, in_txn, owner_ld;
            int          streak, dwell, done_cnt;
            logic [31:0] mdl [16];
            txn_t        cur;

            do_reset();
            for (int i = 0; i < 16; i++) mdl[i] = tb_mem[i];
            mem_rand = 1'b1;
            cpu_pend = 0; ld_pend = 0; prev_cpu = 0; prev_ld = 0;
            in_txn = 0; owner_ld = 0; streak = 0; dwell = 0; done_cnt = 0;

            for (int cyc = 0; cyc < 2300; cyc++) begin
                @(negedge clk);
                if (!in_txn && bus.mem_req) begin
                    check("rnd grant had request", prev_cpu | prev_ld, 1'b1);
                    owner_ld = prev_ld && (!prev_cpu || streak == MAXS);
                    cur = owner_ld ? lt : ct;
                    check("rnd grant payload", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                          {cur.we, cur.addr, cur.wdata});
                    if (owner_ld) streak = 0;
                    else if (prev_ld) streak = (streak < MAXS) ? streak + 1 : MAXS;
                    else streak = 0;
                    in_txn = 1;
                    dwell = 0;
                end else if (in_txn) begin
                    if (bus.cpu_ack || bus.ld_ack) begin
                        check("rnd ack owner", {bus.cpu_ack, bus.ld_ack}, owner_ld ? 2'b01 : 2'b10);
                        if (cur.we) mdl[cur.addr[5:2]] = cur.wdata;
                        else if (owner_ld) exp_ld_rd = mdl[cur.addr[5:2]];
                        else exp_cpu_rd = mdl[cur.addr[5:2]];
                        check("rnd cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
                        check("rnd ld_rdata", bus.ld_rdata, exp_ld_rd);
                        if (owner_ld) ld_pend = 0; else cpu_pend = 0;
                        in_txn = 0;
                        done_cnt++;
                    end else begin
                        dwell++;
                        if (dwell > 10 || bus.mem_req !== 1'b1) begin
                            check("rnd access stalled", {bus.mem_req, 8'(dwell)}, {1'b1, 8'd10});
                            break;
                        end
                    end
                end else begin
                    check("rnd spurious ack", {bus.cpu_ack, bus.ld_ack}, 2'b00);
                end

                if (cyc < 2000) begin
                    if (!cpu_pend && $urandom_range(0, 2) == 0) begin
                        ct.we = $urandom_range(0, 1);
                        ct.addr = 32'($urandom_range(0, 15)) << 2;
                        ct.wdata = $urandom;
                        cpu_pend = 1;
                    end
                    if (!ld_pend && $urandom_range(0, 1) == 0) begin
                        lt.we = $urandom_range(0, 1);
                        lt.addr = 32'($urandom_range(0, 15)) << 2;
                        lt.wdata = $urandom;
                        ld_pend = 1;
                    end
                end else if (!cpu_pend && !ld_pend && !in_txn) begin
                    break;
                end
                bus.cpu_req = cpu_pend; bus.cpu_we = ct.we; bus.cpu_addr = ct.addr; bus.cpu_wdata = ct.wdata;
                bus.ld_req  = ld_pend;  bus.ld_we  = lt.we; bus.ld_addr  = lt.addr; bus.ld_wdata  = lt.wdata;
                prev_cpu = cpu_pend;
                prev_ld  = ld_pend;
            end
            check("rnd drained", {cpu_pend, ld_pend, in_txn}, 3'b000);
            check("rnd progress", done_cnt > 200, 1'b1);
            mem_rand = 1'b0;
            drop_reqs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
